// File: rtl/hazard_fwd_ctrl_if.sv
// D-stage instruction inputs plus the stall and bypass-select outputs
// exchanged between the pipeline (master) and the hazard controller (slave).
interface hazard_fwd_ctrl_if #(
  parameter int REGW = 5
);
  logic            d_valid;
  logic [REGW-1:0] d_rs;
  logic [REGW-1:0] d_rt;
  logic [1:0]      d_tuse_rs;
  logic [1:0]      d_tuse_rt;
  logic [REGW-1:0] d_dst;
  logic [1:0]      d_tnew;
  logic            d_md;
  logic            md_busy;
  logic            stall;
  logic [1:0]      fwd_d_rs;
  logic [1:0]      fwd_d_rt;
  logic [1:0]      fwd_e_rs;
  logic [1:0]      fwd_e_rt;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_md, md_busy,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_md, md_busy,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Tracks dst/Tnew of the E, M and W instructions and derives the stall plus
// the D-comparator and E-ALU bypass mux selects (00 regfile, 01 M, 10 W).
module hazard_fwd_ctrl #(
  parameter int REGW = 5
) (
    input logic             clk,
    input logic             rst_n,
    hazard_fwd_ctrl_if.slave bus
);

    logic [REGW-1:0] e_dst_q, e_dst_d;
    logic [1:0]      e_tnew_q, e_tnew_d;
    logic [REGW-1:0] e_rs_q, e_rs_d;
    logic [REGW-1:0] e_rt_q, e_rt_d;
    logic            e_md_q, e_md_d;
    logic [REGW-1:0] m_dst_q;
    logic [1:0]      m_tnew_q;
    // W.tnew is never consulted: a W match always forwards, so only W.dst is kept.
    logic [REGW-1:0] w_dst_q;

    logic            haz_rs, haz_rt, stall_c;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : 2'(t - 2'd1);
    endfunction

    function automatic logic src_hazard(input logic [REGW-1:0] src,
                                        input logic [1:0]      tuse,
                                        input logic [REGW-1:0] edst,
                                        input logic [1:0]      etnew,
                                        input logic [REGW-1:0] mdst,
                                        input logic [1:0]      mtnew);
        if (src == '0 || tuse == 2'd3) return 1'b0;
        return ((edst == src) && (tuse < etnew)) || ((mdst == src) && (tuse < mtnew));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src,
                                           input logic [REGW-1:0] mdst,
                                           input logic            m_ready,
                                           input logic [REGW-1:0] wdst);
        if (src == '0) return 2'b00;
        if (m_ready && (mdst == src)) return 2'b01;
        if (wdst == src) return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        haz_rs  = src_hazard(bus.d_rs, bus.d_tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
        haz_rt  = src_hazard(bus.d_rt, bus.d_tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
        stall_c = bus.d_valid & (haz_rs | haz_rt | (bus.d_md & (bus.md_busy | e_md_q)));
    end

    always_comb begin
        bus.stall    = stall_c;
        bus.fwd_d_rs = fwd_sel(bus.d_rs, m_dst_q, (m_tnew_q == 2'd0), w_dst_q);
        bus.fwd_d_rt = fwd_sel(bus.d_rt, m_dst_q, (m_tnew_q == 2'd0), w_dst_q);
        bus.fwd_e_rs = fwd_sel(e_rs_q,   m_dst_q, (m_tnew_q == 2'd0), w_dst_q);
        bus.fwd_e_rt = fwd_sel(e_rt_q,   m_dst_q, (m_tnew_q == 2'd0), w_dst_q);
    end

    // A stalled or invalid D slot enters E as an all-zero bubble.
    always_comb begin
        e_dst_d  = '0;
        e_tnew_d = '0;
        e_rs_d   = '0;
        e_rt_d   = '0;
        e_md_d   = 1'b0;
        if (bus.d_valid && !stall_c) begin
            e_dst_d  = bus.d_dst;
            e_tnew_d = bus.d_tnew;
            e_rs_d   = bus.d_rs;
            e_rt_d   = bus.d_rt;
            e_md_d   = bus.d_md;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_dst_q  <= '0;
            e_tnew_q <= '0;
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            e_md_q   <= 1'b0;
            m_dst_q  <= '0;
            m_tnew_q <= '0;
            w_dst_q  <= '0;
        end else begin
            e_dst_q  <= e_dst_d;
            e_tnew_q <= e_tnew_d;
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            e_md_q   <= e_md_d;
            m_dst_q  <= e_dst_q;
            m_tnew_q <= sat_dec(e_tnew_q);
            w_dst_q  <= m_dst_q;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Randomized and directed bench for hazard_fwd_ctrl against an age-based
// model of the E/M/W occupancy, plus literal checks for the classic hazards.
module tb_hazard_fwd_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hazard_fwd_ctrl_if #(.REGW(5)) bus ();

    hazard_fwd_ctrl #(.REGW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Each slot keeps the Tnew it had on entering E; its remaining latency
    // is derived from how many stages it has travelled since then.
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       md;
    } rec_t;

    rec_t pipe [3];
    logic exp_st;

    function automatic int rem(input int k);
        return (int'(pipe[k].tnew) > k) ? int'(pipe[k].tnew) - k : 0;
    endfunction

    function automatic bit m_haz(input logic [4:0] src, input logic [1:0] tuse);
        if (src == 0 || tuse == 3) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (pipe[k].dst == src && int'(tuse) < rem(k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (src == 0) return 2'd0;
        if (pipe[1].dst == src && rem(1) == 0) return 2'd1;
        if (pipe[2].dst == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic m_stall();
        return bus.d_valid && (m_haz(bus.d_rs, bus.d_tuse_rs) || m_haz(bus.d_rt, bus.d_tuse_rt)
               || (bus.d_md && (bus.md_busy || pipe[0].md)));
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic set_d(input bit v, input int rs, input int rt, input int tu_rs,
                         input int tu_rt, input int dst, input int tnew, input bit md);
        bus.d_valid   = v;
        bus.d_rs      = 5'(rs);
        bus.d_rt      = 5'(rt);
        bus.d_tuse_rs = 2'(tu_rs);
        bus.d_tuse_rt = 2'(tu_rt);
        bus.d_dst     = 5'(dst);
        bus.d_tnew    = 2'(tnew);
        bus.d_md      = md;
    endtask

    // Sample away from the rising edge and compare every output with the model.
    task automatic sample_check();
        @(negedge clk);
        exp_st = m_stall();
        chk("stall",    {7'd0, bus.stall}, {7'd0, exp_st});
        chk("fwd_d_rs", {6'd0, bus.fwd_d_rs}, {6'd0, m_fwd(bus.d_rs)});
        chk("fwd_d_rt", {6'd0, bus.fwd_d_rt}, {6'd0, m_fwd(bus.d_rt)});
        chk("fwd_e_rs", {6'd0, bus.fwd_e_rs}, {6'd0, m_fwd(pipe[0].rs)});
        chk("fwd_e_rt", {6'd0, bus.fwd_e_rt}, {6'd0, m_fwd(pipe[0].rt)});
    endtask

    task automatic advance();
        logic st;
        rec_t nxt;
        st  = m_stall();
        nxt = (bus.d_valid && !st) ? rec_t'{bus.d_dst, bus.d_tnew, bus.d_rs, bus.d_rt, bus.d_md}
                                   : rec_t'('0);
        @(posedge clk);
        if (!rst_n) clear_model();
        else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
        end
        #1;
    endtask

    task automatic step();
        sample_check();
        advance();
    endtask

    task automatic bubbles(input int n);
        set_d(0, 0, 0, 3, 3, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        clear_model();
        bus.md_busy = 1'b0;
        set_d(1, 3, 5, 0, 0, 3, 2, 1);
        repeat (2) @(posedge clk);
        // Reset state: nothing matches even with live D inputs.
        sample_check();
        chk("rst_stall", {7'd0, bus.stall}, 8'd0);
        chk("rst_fwd_d_rs", {6'd0, bus.fwd_d_rs}, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bubbles(3);

        // ALU r3 -> consumer -> third consumer
        set_d(1, 1, 2, 1, 1, 3, 1, 0); step();
        set_d(1, 3, 0, 1, 3, 8, 1, 0);
        sample_check(); chk("alu_use_stall", {7'd0, bus.stall}, 8'd0); advance();
        set_d(1, 3, 0, 1, 3, 9, 1, 0);
        sample_check(); chk("alu_use_fwd_e01", {6'd0, bus.fwd_e_rs}, 8'd1); advance();
        set_d(0, 0, 0, 3, 3, 0, 0, 0);
        sample_check(); chk("alu_use_fwd_e10", {6'd0, bus.fwd_e_rs}, 8'd2); advance();
        bubbles(3);

        // Load r5 -> ALU rt=5
        set_d(1, 0, 0, 3, 3, 5, 2, 0); step();
        set_d(1, 1, 5, 1, 1, 6, 1, 0);
        sample_check(); chk("load_use_stall1", {7'd0, bus.stall}, 8'd1); advance();
        sample_check(); chk("load_use_stall2", {7'd0, bus.stall}, 8'd0);
        chk("load_use_bubble", {3'd0, pipe[0].dst}, 8'd0); advance();
        set_d(0, 0, 0, 3, 3, 0, 0, 0);
        sample_check(); chk("load_use_fwd_e10", {6'd0, bus.fwd_e_rt}, 8'd2); advance();
        bubbles(3);

        // ALU r7 -> beq rs=7
        set_d(1, 0, 0, 3, 3, 7, 1, 0); step();
        set_d(1, 7, 0, 0, 3, 0, 0, 0);
        sample_check(); chk("alu_br_stall", {7'd0, bus.stall}, 8'd1); advance();
        sample_check(); chk("alu_br_go", {7'd0, bus.stall}, 8'd0);
        chk("alu_br_fwd01", {6'd0, bus.fwd_d_rs}, 8'd1); advance();
        bubbles(3);

        // Load r7 -> beq rs=7
        set_d(1, 0, 0, 3, 3, 7, 2, 0); step();
        set_d(1, 7, 0, 0, 3, 0, 0, 0);
        sample_check(); chk("ld_br_stall1", {7'd0, bus.stall}, 8'd1); advance();
        sample_check(); chk("ld_br_stall2", {7'd0, bus.stall}, 8'd1); advance();
        sample_check(); chk("ld_br_go", {7'd0, bus.stall}, 8'd0);
        chk("ld_br_fwd10", {6'd0, bus.fwd_d_rs}, 8'd2); advance();
        bubbles(3);

        // Producer writing r0 never stalls or forwards
        set_d(1, 0, 0, 3, 3, 0, 2, 0); step();
        set_d(1, 0, 0, 1, 0, 4, 1, 0);
        sample_check(); chk("r0_stall", {7'd0, bus.stall}, 8'd0);
        chk("r0_fwd_d", {6'd0, bus.fwd_d_rs}, 8'd0); advance();
        bubbles(3);

        // Two writes to r4, M wins over W
        set_d(1, 0, 0, 3, 3, 4, 1, 0); step();
        set_d(1, 0, 0, 3, 3, 4, 1, 0); step();
        set_d(1, 4, 0, 1, 3, 10, 1, 0); step();
        set_d(0, 0, 0, 3, 3, 0, 0, 0);
        sample_check(); chk("m_over_w", {6'd0, bus.fwd_e_rs}, 8'd1); advance();
        bubbles(3);

        // md_busy and md back-to-back
        set_d(1, 0, 0, 3, 3, 0, 0, 1); bus.md_busy = 1'b1;
        sample_check(); chk("md_busy_stall", {7'd0, bus.stall}, 8'd1); advance();
        bus.md_busy = 1'b0; step();
        sample_check(); chk("md_back2back", {7'd0, bus.stall}, 8'd1); advance();
        bubbles(3);

        // Reset asserted mid-stall
        set_d(1, 0, 0, 3, 3, 2, 2, 0); step();
        set_d(1, 0, 2, 3, 1, 6, 1, 0);
        sample_check(); chk("mid_rst_pre", {7'd0, bus.stall}, 8'd1);
        #1 rst_n = 1'b0;
        clear_model();
        #1 chk("mid_rst_stall", {7'd0, bus.stall}, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sample_check(); chk("post_rst_stall", {7'd0, bus.stall}, 8'd0);
        chk("post_rst_fwd_d", {6'd0, bus.fwd_d_rt}, 8'd0); advance();
        set_d(0, 0, 0, 3, 3, 0, 0, 0);
        sample_check(); chk("post_rst_fwd_e", {6'd0, bus.fwd_e_rt}, 8'd0); advance();

        // Randomized traffic; a stalled D instruction is held upstream.
        exp_st = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!(exp_st && bus.d_valid))
                set_d(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                      $urandom_range(0, 2), ($urandom_range(0, 4) == 0));
            bus.md_busy = ($urandom_range(0, 3) == 0);
            if (i == 1500) begin
                #1 rst_n = 1'b0;
                clear_model();
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and bypass controller for the five-stage core. It tracks the destination register and remaining result latency (Tnew) of the instructions in E, M and W. From that state it produces the 2-bit select codes for the 3-input 32-bit bypass muxes on the D-stage comparator operands and the E-stage ALU operands. It also produces the stall that freezes F/D and injects a bubble into E.

## Interface
Parameters:
- REGW, 5, register-index width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- d_valid  in  1  instruction in D is real; 0 means bubble.
- d_rs, d_rt  in  REGW  source register indices of the instruction in D.
- d_tuse_rs, d_tuse_rt  in  2  cycles until D needs each source: 0 = D (branch), 1 = E, 2 = M (store data), 3 = unused.
- d_dst  in  REGW  destination register of the D instruction; 0 = no write.
- d_tnew  in  2  Tnew the instruction carries on entering E: 0 = none/immediate, 1 = ALU result, 2 = load.
- d_md  in  1  D instruction uses the multiply/divide unit.
- md_busy  in  1  multiply/divide unit busy.
- stall  out  1  hold PC and F/D; E receives a bubble.
- fwd_d_rs, fwd_d_rt  out  2  D-comparator mux selects.
- fwd_e_rs, fwd_e_rt  out  2  E-ALU mux selects.

Mux select encoding: 00 = register-file / pipeline value, 01 = M-stage result, 10 = W-stage result, 11 = never driven.

## Operation
- Internal records for E, M and W, each holding {dst[REGW-1:0], tnew[1:0]}. The E record additionally holds {rs, rt}.
- Advance every cycle; there is no global enable:
  - W ← {M.dst, sat(M.tnew−1)}.
  - M ← {E.dst, sat(E.tnew−1)}.
  - E ← {d_dst, d_tnew, d_rs, d_rt} when d_valid & !stall; otherwise all fields 0 (bubble).
  - sat() floors at 0.
- Stall is combinational. It asserts if any of the following holds:
  - For src ∈ {rs, rt} with d_tuse_src ≠ 3 and d_src ≠ 0: (E.dst == d_src & d_tuse_src < E.tnew) or (M.dst == d_src & d_tuse_src < M.tnew).
  - d_md & md_busy.
  - d_md and E holds an md instruction. Track this with a 1-bit E.md field loaded alongside the E record.
- Stall is forced to 0 when d_valid = 0.
- D-stage forwarding for each src:
  - 01 if M.dst == d_src, d_src ≠ 0, M.tnew == 0.
  - Else 10 if W.dst == d_src, d_src ≠ 0.
  - Else 00.
  - E is never a bypass source for D; that case is covered by stall.
- E-stage forwarding for each src, using E.rs / E.rt:
  - 01 if M.dst == E.src, M.tnew == 0, E.src ≠ 0.
  - Else 10 if W.dst == E.src, E.src ≠ 0.
  - Else 00.
- Priority: M over W on a double match (newest value wins).
- Register 0 never matches, so its forwarding is always 00 and it never causes a stall.
- W.tnew is always 0 by construction, because the maximum Tnew of 2 has fully decremented by W.

## Timing
- Reset (rst_n low, asynchronous): all records and E.md clear to 0. stall = 0. All fwd outputs = 00 for any D inputs, since no record matches.
- Release of reset is sampled at the next clk edge. The first D instruction enters E on that edge.
- Stall, fwd_d_* and fwd_e_* are combinational from registered state plus D inputs and settle within the cycle. fwd_e_* depends on registered state only.
- Load-use (Tnew 2, Tuse 1): exactly 1 stall cycle.
- Load → branch (Tuse 0): stall while the load is in E (2 > 0) and in M (1 > 0), for 2 stall cycles total. The branch then takes 10.
- ALU → branch: 1 stall cycle, then 01.
- A stall lasts while the condition holds. Each stalled cycle inserts exactly one bubble in E, and the D inputs are held upstream.
- Reset asserted mid-stall clears all state immediately. Stall drops in the same cycle.
- Simultaneous md_busy and a data hazard: stall = 1 (OR). No priority effect.

## Test plan
- ALU r3 ← …, followed by ALU using rs = 3 (Tuse 1) → stall stays 0. Next cycle fwd_e_rs = 01. The cycle after, a third instruction using r3 sees fwd_e_rs = 10.
- Load r5 (d_tnew = 2), then an ALU instruction with rt = 5 → stall = 1 for exactly 1 cycle. E holds a bubble (E.dst = 0). Then fwd_e_rt = 10.
- ALU r7, then a beq with rs = 7 (Tuse 0) → 1 stall cycle, then fwd_d_rs = 01. With a load r7 instead → 2 stall cycles, then fwd_d_rs = 10.
- A producer writing r0 (d_dst = 0, d_tnew = 2), consumer rs = 0 → stall = 0. All fwd = 00.
- Consecutive writes to r4 by two ALU instructions, consumer rs = 4 → fwd_e_rs = 01 (M wins over W).
- Load r2, a consumer stalls, and rst_n is pulled low mid-stall → stall = 0 at once. After release, E/M/W are empty and the consumer proceeds with fwd = 00.
